// File: rtl/mem_axi_rd_arb.sv
// mem_axi_rd_arb: 2:1 AXI4 read arbiter (AR round-robin, per-master
// outstanding-burst throttle, master index carried in ARID MSB, R routed on RID MSB).
// Ports: chipset_clk/chipset_rst (async, active-high); s0_axi_ar*/r*, s1_axi_ar*/r*
// (master-side AR in, R out); m_axi_ar*/r* (slave-side AR out, R in); rsp_err (sticky).
// Build option: define MEM_AXI_RD_ARB_QOS_EN for higher-arqos-wins arbitration.
module mem_axi_rd_arb #(
   parameter int ID_W      = 6,
   parameter int ADDR_W    = 64,
   parameter int DATA_W    = 512,
   parameter int USER_W    = 1,
   parameter int MAX_OUTST = 4
) (
   input  logic              chipset_clk,
   input  logic              chipset_rst,
   input  logic [ID_W-1:0]   s0_axi_arid,
   input  logic [ADDR_W-1:0] s0_axi_araddr,
   input  logic [7:0]        s0_axi_arlen,
   input  logic [2:0]        s0_axi_arsize,
   input  logic [1:0]        s0_axi_arburst,
   input  logic              s0_axi_arlock,
   input  logic [3:0]        s0_axi_arcache,
   input  logic [2:0]        s0_axi_arprot,
   input  logic [3:0]        s0_axi_arqos,
   input  logic [3:0]        s0_axi_arregion,
   input  logic [USER_W-1:0] s0_axi_aruser,
   input  logic              s0_axi_arvalid,
   output logic              s0_axi_arready,
   output logic [ID_W-1:0]   s0_axi_rid,
   output logic [DATA_W-1:0] s0_axi_rdata,
   output logic [1:0]        s0_axi_rresp,
   output logic              s0_axi_rlast,
   output logic [USER_W-1:0] s0_axi_ruser,
   output logic              s0_axi_rvalid,
   input  logic              s0_axi_rready,
   input  logic [ID_W-1:0]   s1_axi_arid,
   input  logic [ADDR_W-1:0] s1_axi_araddr,
   input  logic [7:0]        s1_axi_arlen,
   input  logic [2:0]        s1_axi_arsize,
   input  logic [1:0]        s1_axi_arburst,
   input  logic              s1_axi_arlock,
   input  logic [3:0]        s1_axi_arcache,
   input  logic [2:0]        s1_axi_arprot,
   input  logic [3:0]        s1_axi_arqos,
   input  logic [3:0]        s1_axi_arregion,
   input  logic [USER_W-1:0] s1_axi_aruser,
   input  logic              s1_axi_arvalid,
   output logic              s1_axi_arready,
   output logic [ID_W-1:0]   s1_axi_rid,
   output logic [DATA_W-1:0] s1_axi_rdata,
   output logic [1:0]        s1_axi_rresp,
   output logic              s1_axi_rlast,
   output logic [USER_W-1:0] s1_axi_ruser,
   output logic              s1_axi_rvalid,
   input  logic              s1_axi_rready,
   output logic [ID_W:0]     m_axi_arid,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic [7:0]        m_axi_arlen,
   output logic [2:0]        m_axi_arsize,
   output logic [1:0]        m_axi_arburst,
   output logic              m_axi_arlock,
   output logic [3:0]        m_axi_arcache,
   output logic [2:0]        m_axi_arprot,
   output logic [3:0]        m_axi_arqos,
   output logic [3:0]        m_axi_arregion,
   output logic [USER_W-1:0] m_axi_aruser,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   input  logic [ID_W:0]     m_axi_rid,
   input  logic [DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rlast,
   input  logic [USER_W-1:0] m_axi_ruser,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready,
   output logic              rsp_err
);

   localparam int CW = $clog2(MAX_OUTST + 1);
   localparam logic [CW-1:0] MAXC = CW'(MAX_OUTST);

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t            state_q, state_d;
   logic              rr_q, gnt_q, gnt;
   logic              arvalid_q, rsp_err_q;
   logic [CW-1:0]     cnt0_q, cnt1_q;
   logic [ID_W:0]     arid_q;
   logic [ADDR_W-1:0] araddr_q;
   logic [7:0]        arlen_q;
   logic [2:0]        arsize_q, arprot_q;
   logic [1:0]        arburst_q;
   logic              arlock_q;
   logic [3:0]        arcache_q, arqos_q, arregion_q;
   logic [USER_W-1:0] aruser_q;

   logic el0, el1, acc, ar_hs, sel, r_last_hs;
   logic inc0, inc1, dec0, dec1;

   assign el0   = s0_axi_arvalid && (cnt0_q < MAXC);
   assign el1   = s1_axi_arvalid && (cnt1_q < MAXC);
   assign acc   = (state_q == IDLE) && (el0 || el1);
   assign ar_hs = arvalid_q && m_axi_arready;

   // State register
   always_ff @(posedge chipset_clk or posedge chipset_rst) begin
      if (chipset_rst) state_q <= IDLE;
      else             state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (el0 || el1) state_d = HOLD;
         HOLD:    if (ar_hs)      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: grant selection and AR ready
   always_comb begin
      gnt = rr_q ? el1 : !el0;
`ifdef MEM_AXI_RD_ARB_QOS_EN
      if (el0 && el1 && (s0_axi_arqos != s1_axi_arqos))
         gnt = (s1_axi_arqos > s0_axi_arqos);
`endif
      // Gated by reset so ready drops in the reset cycle itself
      s0_axi_arready = acc && !gnt && !chipset_rst;
      s1_axi_arready = acc &&  gnt && !chipset_rst;
   end

   // AR payload capture and round-robin pointer
   always_ff @(posedge chipset_clk or posedge chipset_rst) begin
      if (chipset_rst) begin
         arvalid_q  <= 1'b0;
         gnt_q      <= 1'b0;
         rr_q       <= 1'b0;
         arid_q     <= '0;
         araddr_q   <= '0;
         arlen_q    <= '0;
         arsize_q   <= '0;
         arburst_q  <= '0;
         arlock_q   <= 1'b0;
         arcache_q  <= '0;
         arprot_q   <= '0;
         arqos_q    <= '0;
         arregion_q <= '0;
         aruser_q   <= '0;
      end else if (acc) begin
         arvalid_q  <= 1'b1;
         gnt_q      <= gnt;
         arid_q     <= gnt ? {1'b1, s1_axi_arid} : {1'b0, s0_axi_arid};
         araddr_q   <= gnt ? s1_axi_araddr   : s0_axi_araddr;
         arlen_q    <= gnt ? s1_axi_arlen    : s0_axi_arlen;
         arsize_q   <= gnt ? s1_axi_arsize   : s0_axi_arsize;
         arburst_q  <= gnt ? s1_axi_arburst  : s0_axi_arburst;
         arlock_q   <= gnt ? s1_axi_arlock   : s0_axi_arlock;
         arcache_q  <= gnt ? s1_axi_arcache  : s0_axi_arcache;
         arprot_q   <= gnt ? s1_axi_arprot   : s0_axi_arprot;
         arqos_q    <= gnt ? s1_axi_arqos    : s0_axi_arqos;
         arregion_q <= gnt ? s1_axi_arregion : s0_axi_arregion;
         aruser_q   <= gnt ? s1_axi_aruser   : s0_axi_aruser;
      end else if (state_q == HOLD && ar_hs) begin
         arvalid_q <= 1'b0;
         rr_q      <= ~gnt_q;
      end
   end

   assign m_axi_arvalid  = arvalid_q;
   assign m_axi_arid     = arid_q;
   assign m_axi_araddr   = araddr_q;
   assign m_axi_arlen    = arlen_q;
   assign m_axi_arsize   = arsize_q;
   assign m_axi_arburst  = arburst_q;
   assign m_axi_arlock   = arlock_q;
   assign m_axi_arcache  = arcache_q;
   assign m_axi_arprot   = arprot_q;
   assign m_axi_arqos    = arqos_q;
   assign m_axi_arregion = arregion_q;
   assign m_axi_aruser   = aruser_q;

   // R path: steer on RID MSB, no storage
   assign sel           = m_axi_rid[ID_W];
   assign s0_axi_rvalid = m_axi_rvalid && !sel;
   assign s1_axi_rvalid = m_axi_rvalid &&  sel;
   assign m_axi_rready  = sel ? s1_axi_rready : s0_axi_rready;
   assign s0_axi_rid    = m_axi_rid[ID_W-1:0];
   assign s1_axi_rid    = m_axi_rid[ID_W-1:0];
   assign s0_axi_rdata  = m_axi_rdata;
   assign s1_axi_rdata  = m_axi_rdata;
   assign s0_axi_rresp  = m_axi_rresp;
   assign s1_axi_rresp  = m_axi_rresp;
   assign s0_axi_rlast  = m_axi_rlast;
   assign s1_axi_rlast  = m_axi_rlast;
   assign s0_axi_ruser  = m_axi_ruser;
   assign s1_axi_ruser  = m_axi_ruser;

   // Outstanding counters: issue counted at slave AR handshake, retire on last beat
   assign r_last_hs = m_axi_rvalid && m_axi_rready && m_axi_rlast;
   assign inc0 = ar_hs && !gnt_q;
   assign inc1 = ar_hs &&  gnt_q;
   assign dec0 = r_last_hs && !sel;
   assign dec1 = r_last_hs &&  sel;

   always_ff @(posedge chipset_clk or posedge chipset_rst) begin
      if (chipset_rst) begin
         cnt0_q    <= '0;
         cnt1_q    <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         if (inc0 && !dec0)                     cnt0_q <= cnt0_q + 1'b1;
         else if (dec0 && !inc0 && cnt0_q != 0) cnt0_q <= cnt0_q - 1'b1;
         if (inc1 && !dec1)                     cnt1_q <= cnt1_q + 1'b1;
         else if (dec1 && !inc1 && cnt1_q != 0) cnt1_q <= cnt1_q - 1'b1;
         // Last beat for a master with nothing in flight is a protocol error
         if ((dec0 && cnt0_q == 0) || (dec1 && cnt1_q == 0))
            rsp_err_q <= 1'b1;
      end
   end

   assign rsp_err = rsp_err_q;

endmodule
